// File: rtl/cfg_chain_loader.sv
// Serial configuration-chain loader: streams host words LSB-first into a config_cell chain.
// Optional readback verify pass is enabled with macro CFG_LOADER_READBACK_EN.
module cfg_chain_loader #(
    parameter int size      = 32,
    parameter int CHAIN_LEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [size-1:0] word_in,
    input  logic            word_valid,
    output logic            word_ready,
    output logic            chain_out,
    output logic            shift_en,
    input  logic            chain_in,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int BIT_W = $clog2(size + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0] WORD_BITS = BIT_W'(size);

`ifdef CFG_LOADER_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              pass_q, pass_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  wbit_q, wbit_d;
    logic [size-1:0]   sreg_q, sreg_d;
    logic              shift_en_q, shift_en_d;
    logic              chain_out_q, chain_out_d;
    logic              word_ready_q, word_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              start_accept;
    logic [CNT_W-1:0]  cnt_inc;
    logic [BIT_W-1:0]  wbit_inc;

    assign start_accept = (state_q == ST_IDLE) && start && !abort;
    assign cnt_inc      = cnt_q + CNT_ONE;
    assign wbit_inc     = wbit_q + BIT_ONE;

    // chain_out_q is the live LSB; sreg_q holds only the bits still waiting behind it.
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        pass_d       = pass_q;
        cnt_d        = cnt_q;
        wbit_d       = wbit_q;
        sreg_d       = sreg_q;
        shift_en_d   = 1'b0;
        chain_out_d  = 1'b0;
        word_ready_d = word_ready_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    state_d      = ST_FETCH;
                    pass_d       = 1'b0;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    word_ready_d = 1'b1;
                end
            end

            ST_FETCH: begin
                if (abort) begin
                    state_d      = ST_IDLE;
                    pass_d       = 1'b0;
                    busy_d       = 1'b0;
                    word_ready_d = 1'b0;
                end else if (word_valid) begin
                    state_d      = ST_SHIFT;
                    sreg_d       = word_in >> 1;
                    wbit_d       = '0;
                    word_ready_d = 1'b0;
                    shift_en_d   = 1'b1;
                    chain_out_d  = word_in[0];
                end
            end

            ST_SHIFT: begin
                if (abort) begin
                    state_d      = ST_IDLE;
                    pass_d       = 1'b0;
                    busy_d       = 1'b0;
                    word_ready_d = 1'b0;
                end else begin
                    sreg_d = sreg_q >> 1;
                    cnt_d  = cnt_inc;
                    wbit_d = wbit_inc;
                    if (cnt_inc == LAST_BIT) begin
                        // Chain full: leftover high bits of the last word are dropped here.
                        if (READBACK && !pass_q) begin
                            state_d      = ST_FETCH;
                            pass_d       = 1'b1;
                            cnt_d        = '0;
                            word_ready_d = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else if (wbit_inc == WORD_BITS) begin
                        state_d      = ST_FETCH;
                        word_ready_d = 1'b1;
                    end else begin
                        shift_en_d  = 1'b1;
                        chain_out_d = sreg_q[0];
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                pass_d  = 1'b0;
            end

            default: begin
                state_d      = ST_IDLE;
                busy_d       = 1'b0;
                word_ready_d = 1'b0;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pass_q       <= 1'b0;
            cnt_q        <= '0;
            wbit_q       <= '0;
            sreg_q       <= '0;
            shift_en_q   <= 1'b0;
            chain_out_q  <= 1'b0;
            word_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pass_q       <= pass_d;
            cnt_q        <= cnt_d;
            wbit_q       <= wbit_d;
            sreg_q       <= sreg_d;
            shift_en_q   <= shift_en_d;
            chain_out_q  <= chain_out_d;
            word_ready_q <= word_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign shift_en   = shift_en_q;
    assign chain_out  = chain_out_q;
    assign word_ready = word_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef CFG_LOADER_READBACK_EN
    logic err_q;

    // During verify the bit leaving the chain must equal the bit being re-driven into it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (start_accept) begin
            err_q <= 1'b0;
        end else if (pass_q && shift_en_q && (chain_in != chain_out_q)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_chain_in;

    assign unused_chain_in = chain_in;
    assign err             = 1'b0;
`endif

endmodule
